repacketizer_framer: RTL

//  Read-side consumer of the byte fifo: pops a length-prefixed byte stream
//  (1 header byte = payload length L, then L payload bytes) and repacks each

---
 rtl/repacketizer_framer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/repacketizer_framer.sv
// repacketizer_framer: pops a length-prefixed byte stream from a fifo and repacks it into framed words
module repacketizer_framer #(
    parameter int OUT_BYTES  = 4,
    parameter int BCNT_WIDTH = 3,
    parameter int PCNT_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [7:0]             fifo_data_i,
    input  logic                   fifo_empty_i,
    output logic                   fifo_rd_o,
    output logic [OUT_BYTES*8-1:0] out_data_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic                   out_sop_o,
    output logic                   out_eop_o,
    output logic [BCNT_WIDTH-1:0]  out_nbytes_o,
    output logic                   err_zero_len_o,
    output logic [PCNT_WIDTH-1:0]  pkt_count_o
);
    localparam int W  = OUT_BYTES * 8;
    localparam int LW = $clog2(OUT_BYTES);

    typedef enum logic {S_HDR, S_PAY} state_t;

    state_t                state_q, state_d;
    logic [7:0]            remain_q, remain_d;
    logic [LW-1:0]         lane_q, lane_d;
    logic                  first_q, first_d;
    logic [W-1:0]          acc_q, acc_d;
    logic [W-1:0]          data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  sop_q, sop_d;
    logic                  eop_q, eop_d;
    logic [BCNT_WIDTH-1:0] nbytes_q, nbytes_d;
    logic                  err_q, err_d;
    logic [PCNT_WIDTH-1:0] pcnt_q, pcnt_d;
    logic                  pop, accept, close;
    logic [W-1:0]          word_n;

    // A byte is popped only when the output register is free or being drained this cycle
    assign pop    = reset_i & ~fifo_empty_i & (~valid_q | out_ready_i);
    assign accept = valid_q & out_ready_i;

    assign fifo_rd_o      = pop;
    assign out_data_o     = data_q;
    assign out_valid_o    = valid_q;
    assign out_sop_o      = sop_q;
    assign out_eop_o      = eop_q;
    assign out_nbytes_o   = nbytes_q;
    assign err_zero_len_o = err_q;
    assign pkt_count_o    = pcnt_q;

    // Next-state: header parsing, lane assembly, word close and output handshake
    always_comb begin
        word_n = acc_q;
        word_n[(OUT_BYTES - 1 - int'(lane_q)) * 8 +: 8] = fifo_data_i;
        close    = (lane_q == LW'(OUT_BYTES - 1)) || (remain_q == 8'd1);
        state_d  = state_q;
        remain_d = remain_q;
        lane_d   = lane_q;
        first_d  = first_q;
        acc_d    = acc_q;
        data_d   = data_q;
        valid_d  = accept ? 1'b0 : valid_q;
        sop_d    = sop_q;
        eop_d    = eop_q;
        nbytes_d = nbytes_q;
        err_d    = 1'b0;
        pcnt_d   = pcnt_q + PCNT_WIDTH'(accept & eop_q);
        if (pop) begin
            if (state_q == S_HDR) begin
                if (fifo_data_i == 8'd0) begin
                    err_d = 1'b1;
                end else begin
                    remain_d = fifo_data_i;
                    lane_d   = '0;
                    first_d  = 1'b1;
                    acc_d    = '0;
                    state_d  = S_PAY;
                end
            end else begin
                remain_d = remain_q - 8'd1;
                if (close) begin
                    valid_d  = 1'b1;
                    data_d   = word_n;
                    nbytes_d = BCNT_WIDTH'(lane_q) + BCNT_WIDTH'(1);
                    sop_d    = first_q;
                    eop_d    = (remain_q == 8'd1);
                    first_d  = 1'b0;
                    lane_d   = '0;
                    acc_d    = '0;
                    state_d  = (remain_q == 8'd1) ? S_HDR : S_PAY;
                end else begin
                    acc_d  = word_n;
                    lane_d = lane_q + LW'(1);
                end
            end
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q  <= S_HDR;
            remain_q <= '0;
            lane_q   <= '0;
            first_q  <= 1'b0;
            acc_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            nbytes_q <= '0;
            err_q    <= 1'b0;
            pcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            lane_q   <= lane_d;
            first_q  <= first_d;
            acc_q    <= acc_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            nbytes_q <= nbytes_d;
            err_q    <= err_d;
            pcnt_q   <= pcnt_d;
        end
    end
endmodule
